// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// led_pkg : shared types, pixel layout and decode helper for the LED scan path
// Revision : 1.0
// ============================================================================
package led_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRIME   = 2'd1,
    BLANK   = 2'd2,
    DISPLAY = 2'd3
  } led_state_e;

  localparam int PIX_STORED = 3;
  localparam int PIX_G      = 2;
  localparam int PIX_R      = 1;
  localparam int LED_ADDR_W = 8;
  localparam int LED_DATA_W = 4;

  // Bit 0 of the pixel word carries nothing, so only [3:1] is passed in.
  // Returns {lit_g, lit_r}.
  function automatic logic [1:0] pix_decode(input logic [LED_DATA_W-1:1] d);
    return {d[PIX_STORED] & d[PIX_G], d[PIX_STORED] & d[PIX_R]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_scan_driver_if.sv
`default_nettype none
// ============================================================================
// led_scan_driver_if : frame-RAM read port plus LED matrix drive signals
// Revision : 1.0
// ============================================================================
interface led_scan_driver_if
  import led_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8
) ();

  logic                  en;
  logic [LED_ADDR_W-1:0] rd_addr_row;
  logic [LED_ADDR_W-1:0] rd_addr_col;
  logic [LED_DATA_W-1:0] rd_data;
  logic [ROWS-1:0]       row_sel;
  logic [COLS-1:0]       col_r;
  logic [COLS-1:0]       col_g;
  logic                  frame_start;

  modport master (
    input  en, rd_data,
    output rd_addr_row, rd_addr_col, row_sel, col_r, col_g, frame_start
  );

  modport slave (
    output en, rd_data,
    input  rd_addr_row, rd_addr_col, row_sel, col_r, col_g, frame_start
  );

endinterface
`default_nettype wire

// File: rtl/led_row_fetch.sv
`default_nettype none
// ============================================================================
// led_row_fetch : reads one row from the frame RAM into a decoded shadow buffer
// Revision : 1.0
// ============================================================================
module led_row_fetch
  import led_pkg::*;
#(
  parameter int COLS   = 8,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  start_i,
  input  logic [LED_ADDR_W-1:0] row_i,
  input  logic [LED_DATA_W-1:0] rd_data_i,
  output logic [LED_ADDR_W-1:0] rd_addr_row_o,
  output logic [LED_ADDR_W-1:0] rd_addr_col_o,
  output logic [COLS-1:0]       shadow_r_o,
  output logic [COLS-1:0]       shadow_g_o,
  output logic                  done_o
);

  localparam int WIN = COLS + RD_LAT;
  localparam int CW  = (WIN > 1) ? $clog2(WIN) : 1;

  logic [CW-1:0]         cnt_q,    cnt_d;
  logic                  active_q, active_d;
  logic [LED_ADDR_W-1:0] row_q,    row_d;
  logic [LED_ADDR_W-1:0] col_q,    col_d;
  logic [COLS-1:0]       sh_r_q,   sh_r_d;
  logic [COLS-1:0]       sh_g_q,   sh_g_d;
  logic [1:0]            pix;
  logic                  unused_lsb;

  assign pix        = pix_decode(rd_data_i[LED_DATA_W-1:1]);
  assign unused_lsb = rd_data_i[0];

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    row_d    = row_q;
    col_d    = col_q;
    sh_r_d   = sh_r_q;
    sh_g_d   = sh_g_q;
    if (clr_i) begin
      cnt_d    = '0;
      active_d = 1'b0;
      row_d    = '0;
      col_d    = '0;
      sh_r_d   = '0;
      sh_g_d   = '0;
    end else if (start_i) begin
      cnt_d    = '0;
      active_d = 1'b1;
      row_d    = row_i;
      col_d    = '0;
    end else if (active_q) begin
      if (cnt_q < CW'(COLS - 1)) begin
        col_d = LED_ADDR_W'(cnt_q) + LED_ADDR_W'(1);
      end
      // Data seen now belongs to the address issued RD_LAT cycles ago;
      // shifting in from the top leaves column 0 at bit 0.
      if (cnt_q >= CW'(RD_LAT)) begin
        sh_r_d = {pix[0], sh_r_q[COLS-1:1]};
        sh_g_d = {pix[1], sh_g_q[COLS-1:1]};
      end
      if (cnt_q == CW'(WIN - 1)) begin
        cnt_d    = '0;
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      sh_r_q   <= '0;
      sh_g_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      row_q    <= row_d;
      col_q    <= col_d;
      sh_r_q   <= sh_r_d;
      sh_g_q   <= sh_g_d;
    end
  end

  assign rd_addr_row_o = row_q;
  assign rd_addr_col_o = col_q;
  assign shadow_r_o    = sh_r_q;
  assign shadow_g_o    = sh_g_q;
  assign done_o        = active_q && (cnt_q == CW'(WIN - 1));

endmodule
`default_nettype wire

// File: rtl/led_scan_driver.sv
`default_nettype none
// ============================================================================
// led_scan_driver : double-buffered row scanner for an RxC red/green LED matrix
// Revision : 1.0
// ============================================================================
module led_scan_driver
  import led_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DWELL  = 1000,
  parameter int BLANK  = 4,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  led_scan_driver_if.master  bus
);

  localparam int RW = (ROWS  > 1) ? $clog2(ROWS)  : 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;

  if (DWELL < COLS + RD_LAT + 1) begin : g_dwell_check
    $error("DWELL must cover a full row fetch (COLS+RD_LAT+1)");
  end
  if (BLANK < 1) begin : g_blank_check
    $error("BLANK must be at least 1");
  end

  led_state_e      state_q,   state_d;
  logic [RW-1:0]   row_q,     row_d;
  logic [DW-1:0]   dwell_q,   dwell_d;
  logic [BW-1:0]   blank_q,   blank_d;
  logic [ROWS-1:0] row_sel_q, row_sel_d;
  logic [COLS-1:0] col_r_q,   col_r_d;
  logic [COLS-1:0] col_g_q,   col_g_d;
  logic            fs_q,      fs_d;

  logic                  fetch_clr;
  logic                  fetch_start;
  logic [LED_ADDR_W-1:0] fetch_row;
  logic                  fetch_done;
  logic [COLS-1:0]       shadow_r;
  logic [COLS-1:0]       shadow_g;
  logic [RW-1:0]         row_next;

  assign row_next = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);

  led_row_fetch #(
    .COLS   (COLS),
    .RD_LAT (RD_LAT)
  ) u_fetch (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (fetch_clr),
    .start_i       (fetch_start),
    .row_i         (fetch_row),
    .rd_data_i     (bus.rd_data),
    .rd_addr_row_o (bus.rd_addr_row),
    .rd_addr_col_o (bus.rd_addr_col),
    .shadow_r_o    (shadow_r),
    .shadow_g_o    (shadow_g),
    .done_o        (fetch_done)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    dwell_d     = dwell_q;
    blank_d     = blank_q;
    row_sel_d   = row_sel_q;
    col_r_d     = col_r_q;
    col_g_d     = col_g_q;
    fs_d        = 1'b0;
    fetch_clr   = 1'b0;
    fetch_start = 1'b0;
    fetch_row   = LED_ADDR_W'(row_next);
    if (!bus.en) begin
      state_d   = led_pkg::IDLE;
      row_d     = '0;
      dwell_d   = '0;
      blank_d   = '0;
      row_sel_d = '0;
      col_r_d   = '0;
      col_g_d   = '0;
      fetch_clr = 1'b1;
    end else begin
      case (state_q)
        led_pkg::IDLE: begin
          state_d     = led_pkg::PRIME;
          row_d       = '0;
          fetch_start = 1'b1;
          fetch_row   = '0;
        end
        led_pkg::PRIME: begin
          if (fetch_done) begin
            state_d = led_pkg::BLANK;
            blank_d = '0;
          end
        end
        led_pkg::BLANK: begin
          if (blank_q == BW'(BLANK - 1)) begin
            // Load the lit row and start prefetching the following one.
            state_d     = led_pkg::DISPLAY;
            blank_d     = '0;
            dwell_d     = '0;
            row_sel_d   = ROWS'(1) << row_q;
            col_r_d     = shadow_r;
            col_g_d     = shadow_g;
            fs_d        = (row_q == '0);
            fetch_start = 1'b1;
          end else begin
            blank_d = blank_q + BW'(1);
          end
        end
        led_pkg::DISPLAY: begin
          if (dwell_q == DW'(DWELL - 1)) begin
            state_d   = led_pkg::BLANK;
            dwell_d   = '0;
            row_d     = row_next;
            row_sel_d = '0;
            col_r_d   = '0;
            col_g_d   = '0;
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end
        default: state_d = led_pkg::IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= led_pkg::IDLE;
      row_q     <= '0;
      dwell_q   <= '0;
      blank_q   <= '0;
      row_sel_q <= '0;
      col_r_q   <= '0;
      col_g_q   <= '0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      dwell_q   <= dwell_d;
      blank_q   <= blank_d;
      row_sel_q <= row_sel_d;
      col_r_q   <= col_r_d;
      col_g_q   <= col_g_d;
      fs_q      <= fs_d;
    end
  end

  assign bus.row_sel     = row_sel_q;
  assign bus.col_r       = col_r_q;
  assign bus.col_g       = col_g_q;
  assign bus.frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_led_scan_driver.sv
`default_nettype none
// ============================================================================
// tb_led_scan_driver : directed bench, 8x8 matrix, DWELL=12, BLANK=3, RD_LAT=1
// Revision : 1.0
// ============================================================================
module tb_led_scan_driver;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  logic [3:0] ram [8][8];
  logic [7:0] er  [8];
  logic [7:0] eg  [8];

  always #5 clk = ~clk;

  led_scan_driver_if #(.ROWS(8), .COLS(8)) bus ();

  led_scan_driver #(
    .ROWS   (8),
    .COLS   (8),
    .DWELL  (12),
    .BLANK  (3),
    .RD_LAT (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One-cycle-latency RAM model
  always @(posedge clk)
    bus.rd_data <= ram[bus.rd_addr_row[2:0]][bus.rd_addr_col[2:0]];

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, ".row_sel"}, 32'(bus.row_sel), 32'h0);
    chk({tag, ".col_r"},   32'(bus.col_r),   32'h0);
    chk({tag, ".col_g"},   32'(bus.col_g),   32'h0);
    chk({tag, ".fs"},      32'(bus.frame_start), 32'h0);
  endtask

  // Entered on the first DISPLAY cycle of row r; returns on the next row's first.
  task automatic chk_row(input int r, input logic [7:0] exp_r, input logic [7:0] exp_g);
    logic [7:0] sel;
    sel = 8'(1 << r);
    chk($sformatf("r%0d.row_sel", r), 32'(bus.row_sel), 32'(sel));
    chk($sformatf("r%0d.col_r", r),   32'(bus.col_r),   32'(exp_r));
    chk($sformatf("r%0d.col_g", r),   32'(bus.col_g),   32'(exp_g));
    chk($sformatf("r%0d.fs", r),      32'(bus.frame_start), 32'(r == 0));
    chk($sformatf("r%0d.addr_row", r), 32'(bus.rd_addr_row), 32'((r + 1) % 8));
    chk($sformatf("r%0d.addr_col", r), 32'(bus.rd_addr_col), 32'h0);
    step(1);
    chk($sformatf("r%0d.fs_drop", r), 32'(bus.frame_start), 32'h0);
    step(10);
    chk($sformatf("r%0d.sel_held", r),  32'(bus.row_sel), 32'(sel));
    chk($sformatf("r%0d.colr_held", r), 32'(bus.col_r),   32'(exp_r));
    chk($sformatf("r%0d.col_hold", r),  32'(bus.rd_addr_col), 32'h7);
    step(1);
    chk_dark($sformatf("r%0d.blank0", r));
    step(2);
    chk_dark($sformatf("r%0d.blank2", r));
    step(1);
  endtask

  initial begin
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        ram[r][c] = 4'b0111;
    rst    = 1'b1;
    bus.en = 1'b1;
    step(2);
    chk_dark("reset");
    chk("reset.addr_row", 32'(bus.rd_addr_row), 32'h0);
    chk("reset.addr_col", 32'(bus.rd_addr_col), 32'h0);

    rst = 1'b0;
    step(1);
    chk("prime.col0", 32'(bus.rd_addr_col), 32'h0);
    step(3);
    chk("prime.col3", 32'(bus.rd_addr_col), 32'h3);
    step(8);
    chk_dark("pre_first_row");
    step(1);

    for (int f = 1; f <= 4; f++) begin
      for (int r = 0; r < 8; r++) begin
        er[r] = 8'h00;
        eg[r] = 8'h00;
      end
      if (f >= 2) er[2] = 8'h20;
      if (f >= 3) eg[2] = 8'h20;
      if (f == 4) er[4] = 8'h01;
      for (int r = 0; r < 8; r++) begin
        if (f == 2 && r == 0) begin
          for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
              ram[a][b] = 4'b0000;
          ram[2][5] = 4'b1010;
        end
        if (f == 3 && r == 0) ram[2][5] = 4'b1110;
        if (f == 3 && r == 4) ram[4][0] = 4'b1010;
        chk_row(r, er[r], eg[r]);
      end
    end

    chk_row(0, 8'h00, 8'h00);
    chk_row(1, 8'h00, 8'h00);
    chk_row(2, 8'h20, 8'h20);
    step(4);
    bus.en = 1'b0;
    step(1);
    chk_dark("en_drop");
    chk("en_drop.addr_row", 32'(bus.rd_addr_row), 32'h0);
    chk("en_drop.addr_col", 32'(bus.rd_addr_col), 32'h0);
    ram[0][3] = 4'b1110;
    step(5);
    chk_dark("idle");
    bus.en = 1'b1;
    step(12);
    chk_dark("restart_blank");
    step(1);
    chk_row(0, 8'h08, 8'h08);
    chk_row(1, 8'h00, 8'h00);

    step(3);
    rst = 1'b1;
    #1;
    chk_dark("async_rst");
    chk("async_rst.addr_row", 32'(bus.rd_addr_row), 32'h0);
    step(1);
    rst = 1'b0;
    step(12);
    chk_dark("post_rst_blank");
    step(1);
    chk("post_rst.row_sel", 32'(bus.row_sel), 32'h01);
    chk("post_rst.col_r",   32'(bus.col_r),   32'h08);
    chk("post_rst.fs",      32'(bus.frame_start), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
